text_line: RTL and testbench

- Parametrised successor to the fixed two-letter word renderer.
- Holds a writable buffer of NUM_LETTERS letter codes placed on a fixed pitch.
- Decides per pixel whether a letter cell is hit, and outputs a registered draw flag, letter code and in-cell offsets for the existing letter glyph module.
- Adds a frame-driven typewriter reveal state machine, so score and banner text can be rewritten and animated at run time.

---
 rtl/text_line.sv | 201 ++++++++++++++++++++
 tb/tb_text_line.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line.sv
// Renders a writable line of NUM_LETTERS letter cells with a frame-driven typewriter reveal.
// Optional blinking of the idle text is enabled by defining TEXT_LINE_BLINK_EN.

`ifndef LETTER_WIDTH
`define LETTER_WIDTH 32
`endif
`ifndef LETTER_HEIGHT
`define LETTER_HEIGHT 32
`endif

module text_line #(
    parameter int NUM_LETTERS       = 8,
    parameter int CODE_W            = 4,
    parameter int TOP_LEFT_X        = 200,
    parameter int TOP_LEFT_Y        = 5,
    parameter int PITCH             = 50,
    parameter int FRAMES_PER_LETTER = 15,
    parameter int BLINK_FRAMES      = 30,
    parameter int LETTER_WIDTH      = `LETTER_WIDTH,
    parameter int LETTER_HEIGHT     = `LETTER_HEIGHT,
    localparam int ADDR_W           = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [10:0]       pixelX,
    input  logic [10:0]       pixelY,
    input  logic              startOfFrame,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [CODE_W-1:0] wrData,
    input  logic              revealStart,
    output logic              revealDone,
    output logic              drawLetter,
    output logic [CODE_W-1:0] letterCode,
    output logic [10:0]       offsetX,
    output logic [10:0]       offsetY,
    output logic [1:0]        dbgState
);

    localparam int VC_W = $clog2(NUM_LETTERS + 1);
    localparam int FC_W = $clog2(FRAMES_PER_LETTER + 1);
    localparam logic [CODE_W-1:0] BLANK = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        DONE   = 2'd2
    } stateT;

    generate
        if (NUM_LETTERS < 1 || NUM_LETTERS > 16) begin : gBadNum
            $error("text_line: NUM_LETTERS must be 1..16");
        end
        if (PITCH < LETTER_WIDTH) begin : gBadPitch
            $error("text_line: PITCH must be >= LETTER_WIDTH");
        end
        if (FRAMES_PER_LETTER < 1 || BLINK_FRAMES < 1) begin : gBadFrames
            $error("text_line: frame counts must be >= 1");
        end
    endgenerate

    stateT             state, stateNext;
    logic [VC_W-1:0]   visibleCount, vcNext;
    logic [FC_W-1:0]   frameCnt, fcNext;
    logic [CODE_W-1:0] buffer [NUM_LETTERS];

    logic              hitAny;
    logic [CODE_W-1:0] hitCode;
    logic [10:0]       hitOffX;
    logic              rowHit;
    logic              blinkOff;

    function automatic logic [10:0] cellLeft(input int idx);
        return 11'(TOP_LEFT_X + idx * PITCH);
    endfunction

    function automatic logic [10:0] cellRight(input int idx);
        return 11'(TOP_LEFT_X + idx * PITCH + LETTER_WIDTH);
    endfunction

    assign dbgState = state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_LETTERS; i++) buffer[i] <= BLANK;
        end else if (wrEn && (int'(wrAddr) < NUM_LETTERS)) begin
            buffer[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            visibleCount <= VC_W'(NUM_LETTERS);
            frameCnt     <= '0;
        end else begin
            state        <= stateNext;
            visibleCount <= vcNext;
            frameCnt     <= fcNext;
        end
    end

    // A restart pulse overrides everything, including a frame tick or a pending DONE.
    always_comb begin
        stateNext  = state;
        vcNext     = visibleCount;
        fcNext     = frameCnt;
        revealDone = 1'b0;
        if (revealStart) begin
            stateNext = REVEAL;
            vcNext    = '0;
            fcNext    = '0;
        end else begin
            case (state)
                IDLE: vcNext = VC_W'(NUM_LETTERS);
                REVEAL: begin
                    if (startOfFrame) begin
                        if (frameCnt == FC_W'(FRAMES_PER_LETTER - 1)) begin
                            fcNext = '0;
                            if (visibleCount == VC_W'(NUM_LETTERS - 1)) begin
                                stateNext = DONE;
                                vcNext    = VC_W'(NUM_LETTERS);
                            end else begin
                                vcNext = visibleCount + VC_W'(1);
                            end
                        end else begin
                            fcNext = frameCnt + FC_W'(1);
                        end
                    end
                end
                DONE: begin
                    revealDone = 1'b1;
                    vcNext     = VC_W'(NUM_LETTERS);
                    stateNext  = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

`ifdef TEXT_LINE_BLINK_EN
    localparam int BC_W = $clog2(BLINK_FRAMES + 1);
    logic [BC_W-1:0] blinkCnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blinkCnt <= '0;
            blinkOff <= 1'b0;
        end else if (revealStart) begin
            blinkCnt <= '0;
            blinkOff <= 1'b0;
        end else if (state == IDLE && startOfFrame) begin
            if (blinkCnt == BC_W'(BLINK_FRAMES - 1)) begin
                blinkCnt <= '0;
                blinkOff <= ~blinkOff;
            end else begin
                blinkCnt <= blinkCnt + BC_W'(1);
            end
        end
    end
`else
    assign blinkOff = 1'b0;
`endif

    assign rowHit = (pixelY >= 11'(TOP_LEFT_Y)) && (pixelY < 11'(TOP_LEFT_Y + LETTER_HEIGHT));

    // Cells never overlap, so at most one iteration can match.
    always_comb begin
        hitAny  = 1'b0;
        hitCode = '0;
        hitOffX = '0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (rowHit && pixelX >= cellLeft(i) && pixelX < cellRight(i) &&
                VC_W'(i) < visibleCount && buffer[i] != BLANK) begin
                hitAny  = 1'b1;
                hitCode = buffer[i];
                hitOffX = pixelX - cellLeft(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawLetter <= 1'b0;
            letterCode <= '0;
            offsetX    <= '0;
            offsetY    <= '0;
        end else if (hitAny && !blinkOff) begin
            drawLetter <= 1'b1;
            letterCode <= hitCode;
            offsetX    <= hitOffX;
            offsetY    <= pixelY - 11'(TOP_LEFT_Y);
        end else begin
            drawLetter <= 1'b0;
            letterCode <= '0;
            offsetX    <= '0;
            offsetY    <= '0;
        end
    end

endmodule

// File: tb/tb_text_line.sv
// Scoreboard bench for text_line: drivers push expected pixel responses, a monitor pops and compares.
// Build with +define+TEXT_LINE_BLINK_EN (bench and RTL) to exercise the blinking section.

module tb_text_line;

  localparam int W = 27;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        wrEn = 1'b0;
  logic [2:0]  wrAddr = '0;
  logic [3:0]  wrData = '0;
  logic        revealStart = 1'b0;
  logic        revealDone;
  logic        drawLetter;
  logic [3:0]  letterCode;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [1:0]  dbgState;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic pix_valid = 1'b0;
  logic chk_valid = 1'b0;

  text_line dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .revealStart(revealStart), .revealDone(revealDone), .drawLetter(drawLetter),
    .letterCode(letterCode), .offsetX(offsetX), .offsetY(offsetY), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // handshake: pix_valid marks a driven pixel; its response is checked one clock later
  always @(posedge clk or negedge resetN)
    if (!resetN) chk_valid <= 1'b0;
    else chk_valid <= pix_valid;

  always @(negedge clk)
    if (resetN && revealDone) done_cnt++;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) check("queue_underflow", 32'd1, 32'd0);
      else check("pixel", 32'({drawLetter, letterCode, offsetX, offsetY}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic pix(input int x, input int y, input logic d, input logic [3:0] c,
                     input int ox, input int oy);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    pix_valid = 1'b1;
    exp_q.push_back({d, c, 11'(ox), 11'(oy)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    pix_valid = 1'b0;
    wrEn = 1'b1;
    wrAddr = 3'(a);
    wrData = 4'(d);
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
    end
  endtask

  task automatic start_pulse(input logic with_frame);
    @(negedge clk);
    pix_valid = 1'b0;
    revealStart = 1'b1;
    startOfFrame = with_frame;
    @(negedge clk);
    revealStart = 1'b0;
    startOfFrame = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_draw", 32'(drawLetter), 32'd0);
    check("rst_code", 32'(letterCode), 32'd0);
    check("rst_offx", 32'(offsetX), 32'd0);
    check("rst_offy", 32'(offsetY), 32'd0);
    check("rst_done", 32'(revealDone), 32'd0);
    check("rst_state", 32'(dbgState), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // all cells blank after reset
    for (int x = 190; x <= 600; x += 10) pix(x, 10, 1'b0, 4'd0, 0, 0);

    // load codes 0..7 and probe cell edges
    for (int i = 0; i < 8; i++) wr(i, i);
    pix(250, 5, 1'b1, 4'd1, 0, 0);
    pix(232, 5, 1'b0, 4'd0, 0, 0);
    pix(200, 36, 1'b1, 4'd0, 0, 31);
    pix(231, 20, 1'b1, 4'd0, 31, 15);
    pix(350, 10, 1'b1, 4'd3, 0, 5);
    pix(581, 36, 1'b1, 4'd7, 31, 31);
    pix(582, 10, 1'b0, 4'd0, 0, 0);
    pix(300, 37, 1'b0, 4'd0, 0, 0);
    pix(300, 4, 1'b0, 4'd0, 0, 0);
    pix(199, 5, 1'b0, 4'd0, 0, 0);

    // blank cell 2
    wr(2, 15);
    pix(300, 10, 1'b0, 4'd0, 0, 0);
    pix(331, 10, 1'b0, 4'd0, 0, 0);
    pix(400, 10, 1'b1, 4'd4, 0, 5);

    // write to the cell being hit in the same cycle
    @(negedge clk);
    pixelX = 11'd250; pixelY = 11'd5; pix_valid = 1'b1;
    wrEn = 1'b1; wrAddr = 3'd1; wrData = 4'd9;
    exp_q.push_back({1'b1, 4'd1, 11'd0, 11'd0});
    @(negedge clk);
    wrEn = 1'b0;
    exp_q.push_back({1'b1, 4'd9, 11'd0, 11'd0});
    idle(1);

    // full reveal
    start_pulse(1'b0);
    check("state_reveal", 32'(dbgState), 32'd1);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    frames(14);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    frames(1);
    pix(200, 5, 1'b1, 4'd0, 0, 0);
    pix(250, 5, 1'b0, 4'd0, 0, 0);
    frames(104);
    pix(500, 5, 1'b1, 4'd6, 0, 0);
    pix(550, 5, 1'b0, 4'd0, 0, 0);
    idle(1);
    check("done_before_end", 32'(done_cnt), 32'd0);
    frames(1);
    idle(3);
    check("done_once", 32'(done_cnt), 32'd1);
    check("state_idle_after", 32'(dbgState), 32'd0);
    pix(550, 5, 1'b1, 4'd7, 0, 0);
    pix(250, 5, 1'b1, 4'd9, 0, 0);

    // restart mid-reveal
    start_pulse(1'b0);
    frames(40);
    pix(250, 5, 1'b1, 4'd9, 0, 0);
    start_pulse(1'b0);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    idle(2);
    check("no_done_restart", 32'(done_cnt), 32'd1);

    // restart and frame tick together: the tick is not counted
    start_pulse(1'b1);
    frames(14);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    frames(1);
    pix(200, 5, 1'b1, 4'd0, 0, 0);
    frames(15);
    pix(250, 5, 1'b1, 4'd9, 0, 0);
    pix(350, 5, 1'b0, 4'd0, 0, 0);
    pix(200, 5, 1'b1, 4'd0, 0, 0);
    idle(2);

    // asynchronous reset in the middle of a reveal
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("mid_rst_draw", 32'(drawLetter), 32'd0);
    check("mid_rst_state", 32'(dbgState), 32'd0);
    check("mid_rst_done", 32'(revealDone), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    wr(0, 3);
    pix(200, 5, 1'b1, 4'd3, 0, 0);
    wr(7, 5);
    pix(580, 30, 1'b1, 4'd5, 30, 25);
    idle(2);
    check("no_done_rst", 32'(done_cnt), 32'd1);

`ifdef TEXT_LINE_BLINK_EN
    frames(29);
    pix(200, 5, 1'b1, 4'd3, 0, 0);
    frames(1);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    frames(29);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    frames(1);
    pix(200, 5, 1'b1, 4'd3, 0, 0);
    frames(30);
    pix(200, 5, 1'b0, 4'd0, 0, 0);
    start_pulse(1'b0);
    frames(15);
    pix(200, 5, 1'b1, 4'd3, 0, 0);
`else
    frames(30);
    pix(200, 5, 1'b1, 4'd3, 0, 0);
`endif

    // final report
    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
